// File: rtl/led_ctrl_pkg.sv
// Shared encodings for the LED pattern sequencer: display modes and FSM states.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_LEFT   = 2'b00,
    MODE_RIGHT  = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/step_prescaler.sv
// Step pacing counter: emits a one-cycle step pulse every SHIFT_TIME enabled cycles.
module step_prescaler #(
  parameter int SHIFT_TIME = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic step
);

  localparam int CW = $clog2(SHIFT_TIME + 1);
  localparam logic [CW-1:0] LAST = CW'(SHIFT_TIME - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign step = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = step ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED pattern sequencer: IDLE/RUN control, mode latch, and per-step pattern generation
// for ripple-left, ripple-right, bounce and blink, with a period-complete pulse.
module led_pattern_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int SHIFT_TIME = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] led,
  output logic             busy,
  output logic             cycle_done
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             clr, en, step;

  function automatic logic [WIDTH-1:0] init_pattern(input mode_e m);
    logic [WIDTH-1:0] p;
    p = '0;
    case (m)
      MODE_RIGHT: p[WIDTH-1] = 1'b1;
      MODE_BLINK: p = '1;
      default:    p[0] = 1'b1;
    endcase
    return p;
  endfunction

  // Prescaler is restarted on the load edge and on stop so every run begins at count 0.
  assign en  = (state_q == ST_RUN) && !stop;
  assign clr = ((state_q == ST_IDLE) && start && !stop) || ((state_q == ST_RUN) && stop);

  step_prescaler #(
    .SHIFT_TIME(SHIFT_TIME)
  ) u_presc (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (en),
    .step(step)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    led_d   = led_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        led_d  = '0;
        busy_d = 1'b0;
        if (start && !stop) begin
          state_d = ST_RUN;
          mode_d  = mode_e'(mode);
          dir_d   = 1'b0;
          busy_d  = 1'b1;
          led_d   = init_pattern(mode_e'(mode));
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
          led_d   = '0;
          busy_d  = 1'b0;
        end else if (step) begin
          case (mode_q)
            MODE_LEFT: begin
              led_d  = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
              done_d = led_q[WIDTH-1];
            end
            MODE_RIGHT: begin
              led_d  = {led_q[0], led_q[WIDTH-1:1]};
              done_d = led_q[0];
            end
            MODE_BOUNCE: begin
              // Direction flips on arrival at an end, so the end bit is never held twice.
              if (!dir_q) begin
                led_d = led_q << 1;
                if (led_q[WIDTH-2]) dir_d = 1'b1;
              end else begin
                led_d = led_q >> 1;
                if (led_q[1]) begin
                  dir_d  = 1'b0;
                  done_d = 1'b1;
                end
              end
            end
            default: begin
              led_d  = ~led_q;
              done_d = &(~led_q);
            end
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_LEFT;
      dir_q   <= 1'b0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign led        = led_q;
  assign busy       = busy_q;
  assign cycle_done = done_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl: a vector table plus full-period walks per mode.
module tb_led_pattern_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic [1:0] mode;
  logic [7:0] led;
  logic       busy;
  logic       cycle_done;

  int total = 0;
  int bad   = 0;

  led_pattern_ctrl #(
    .WIDTH(8),
    .SHIFT_TIME(5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .led       (led),
    .busy      (busy),
    .cycle_done(cycle_done)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       start;
    logic       stop;
    logic [1:0] mode;
    int         ticks;
    logic [7:0] led;
    logic       busy;
    logic       cd;
  } vec_t;

  localparam int NV = 30;
  vec_t tbl[NV];

  function automatic vec_t mk(input logic r, input logic st, input logic sp, input logic [1:0] m,
                              input int t, input logic [7:0] l, input logic b, input logic c);
    vec_t v;
    v.rst = r; v.start = st; v.stop = sp; v.mode = m;
    v.ticks = t; v.led = l; v.busy = b; v.cd = c;
    return v;
  endfunction

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h expected=%0h", nm, idx, got, exp);
    end
  endtask

  task automatic chk_out(input string nm, input int idx, input logic [7:0] l, input logic b, input logic c);
    chk({nm, ".led"}, idx, {24'd0, led}, {24'd0, l});
    chk({nm, ".busy"}, idx, {31'd0, busy}, {31'd0, b});
    chk({nm, ".cd"}, idx, {31'd0, cycle_done}, {31'd0, c});
  endtask

  // Reference pattern after s steps from load, and whether step s closes a period.
  function automatic logic [7:0] exp_led(input logic [1:0] m, input int s);
    int p;
    case (m)
      2'b00:   return 8'h01 << (s % 8);
      2'b01:   return 8'h80 >> (s % 8);
      2'b10: begin
        p = s % 14;
        return (p <= 7) ? (8'h01 << p) : (8'h01 << (14 - p));
      end
      default: return (s % 2 == 0) ? 8'hFF : 8'h00;
    endcase
  endfunction

  function automatic logic exp_cd(input logic [1:0] m, input int s);
    if (s == 0) return 1'b0;
    case (m)
      2'b00, 2'b01: return (s % 8) == 0;
      2'b10:        return (s % 14) == 0;
      default:      return (s % 2) == 0;
    endcase
  endfunction

  task automatic run_mode(input logic [1:0] m, input int nsteps);
    string nm;
    nm = $sformatf("walk_m%0d", m);
    start = 1'b1; stop = 1'b0; mode = m;
    ticks(1);
    chk_out({nm, "_load"}, 0, exp_led(m, 0), 1'b1, 1'b0);
    start = 1'b0;
    for (int s = 1; s <= nsteps; s++) begin
      for (int k = 0; k < 4; k++) begin
        ticks(1);
        chk({nm, "_hold.led"}, s, {24'd0, led}, {24'd0, exp_led(m, s - 1)});
        chk({nm, "_hold.cd"}, s, {31'd0, cycle_done}, 32'd0);
      end
      ticks(1);
      chk_out({nm, "_step"}, s, exp_led(m, s), 1'b1, exp_cd(m, s));
    end
    stop = 1'b1;
    ticks(1);
    chk_out({nm, "_stop"}, 0, 8'h00, 1'b0, 1'b0);
    stop = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00;

    // reset with start held, then ripple-left
    tbl[0]  = mk(1, 1, 0, 2'd0, 1, 8'h00, 0, 0);
    tbl[1]  = mk(1, 1, 0, 2'd0, 1, 8'h00, 0, 0);
    tbl[2]  = mk(1, 1, 0, 2'd0, 1, 8'h00, 0, 0);
    tbl[3]  = mk(0, 1, 0, 2'd0, 1, 8'h01, 1, 0);
    tbl[4]  = mk(0, 0, 0, 2'd0, 4, 8'h01, 1, 0);
    tbl[5]  = mk(0, 0, 0, 2'd0, 1, 8'h02, 1, 0);
    tbl[6]  = mk(0, 0, 0, 2'd0, 30, 8'h80, 1, 0);
    tbl[7]  = mk(0, 0, 0, 2'd0, 4, 8'h80, 1, 0);
    tbl[8]  = mk(0, 0, 0, 2'd0, 1, 8'h01, 1, 1);
    tbl[9]  = mk(0, 0, 0, 2'd0, 1, 8'h01, 1, 0);
    tbl[10] = mk(0, 0, 1, 2'd0, 1, 8'h00, 0, 0);
    tbl[11] = mk(0, 0, 0, 2'd0, 1, 8'h00, 0, 0);
    // blink, mode changed mid-run
    tbl[12] = mk(0, 1, 0, 2'd3, 1, 8'hFF, 1, 0);
    tbl[13] = mk(0, 0, 0, 2'd0, 4, 8'hFF, 1, 0);
    tbl[14] = mk(0, 0, 0, 2'd0, 1, 8'h00, 1, 0);
    tbl[15] = mk(0, 0, 0, 2'd0, 4, 8'h00, 1, 0);
    tbl[16] = mk(0, 0, 0, 2'd0, 1, 8'hFF, 1, 1);
    tbl[17] = mk(0, 0, 0, 2'd0, 1, 8'hFF, 1, 0);
    tbl[18] = mk(0, 0, 0, 2'd0, 4, 8'h00, 1, 0);
    tbl[19] = mk(0, 0, 1, 2'd0, 1, 8'h00, 0, 0);
    // ripple-right, stop at 0x20, then start+stop together
    tbl[20] = mk(0, 1, 0, 2'd1, 1, 8'h80, 1, 0);
    tbl[21] = mk(0, 0, 0, 2'd1, 5, 8'h40, 1, 0);
    tbl[22] = mk(0, 0, 0, 2'd1, 5, 8'h20, 1, 0);
    tbl[23] = mk(0, 0, 1, 2'd1, 1, 8'h00, 0, 0);
    tbl[24] = mk(0, 1, 1, 2'd1, 3, 8'h00, 0, 0);
    tbl[25] = mk(0, 0, 0, 2'd1, 1, 8'h00, 0, 0);
    // stop landing exactly on a step edge
    tbl[26] = mk(0, 1, 0, 2'd0, 1, 8'h01, 1, 0);
    tbl[27] = mk(0, 0, 0, 2'd0, 4, 8'h01, 1, 0);
    tbl[28] = mk(0, 0, 1, 2'd0, 1, 8'h00, 0, 0);
    tbl[29] = mk(0, 0, 0, 2'd0, 1, 8'h00, 0, 0);

    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      rst = tbl[i].rst; start = tbl[i].start; stop = tbl[i].stop; mode = tbl[i].mode;
      ticks(tbl[i].ticks);
      chk_out("vec", i, tbl[i].led, tbl[i].busy, tbl[i].cd);
    end

    // full periods of every mode
    run_mode(2'd0, 9);
    run_mode(2'd1, 9);
    run_mode(2'd2, 15);
    run_mode(2'd3, 5);

    // reset pulse on a step edge, then a clean restart
    start = 1'b1; mode = 2'd0;
    ticks(1);
    chk_out("rst_mid_load", 0, 8'h01, 1'b1, 1'b0);
    start = 1'b0;
    ticks(4);
    rst = 1'b1;
    ticks(1);
    chk_out("rst_mid", 0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    ticks(1);
    chk_out("rst_mid_idle", 0, 8'h00, 1'b0, 1'b0);
    start = 1'b1;
    ticks(1);
    chk_out("restart_load", 0, 8'h01, 1'b1, 1'b0);
    start = 1'b0;
    ticks(4);
    chk_out("restart_hold", 0, 8'h01, 1'b1, 1'b0);
    ticks(1);
    chk_out("restart_step", 0, 8'h02, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
Sequencer for the 8-bit LED rippling datapath. It selects one of four display patterns, paces pattern steps with an internal prescaler (SHIFT_TIME clocks per step), and provides start/stop control. It also reports run status and a once-per-pattern-period completion pulse. It sits between board control inputs (switches/buttons) and the LED pins.

Parameters:
WIDTH, 8, number of LEDs driven; must be >= 2
SHIFT_TIME, 5, clock cycles per pattern step; must be >= 1

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous, active-high reset
start  input  1  level-sampled; begins a run when idle
stop  input  1  level-sampled; ends a run; priority over start
mode  input  2  00 ripple-left, 01 ripple-right, 10 bounce, 11 blink
led  output  WIDTH  registered LED drive
busy  output  1  high while in RUN
cycle_done  output  1  one-cycle pulse at completion of each pattern period

Behaviour:
- One clock (clk). Reset is synchronous and active-high on rst.
- rst overrides every other input on any edge, including mid-run. After reset:
  - state=IDLE, led=0, busy=0, cycle_done=0
  - prescaler=0, bounce direction=left, latched mode=00
- All outputs are registered. No combinational path from inputs to outputs.
- FSM has two states, IDLE and RUN.
- IDLE:
  - led=0, busy=0.
  - stop=1: remain IDLE (also when start=1 in the same cycle).
  - start=1 and stop=0: go to RUN on the next edge. In that same edge:
    - latch mode into mode_q
    - clear the prescaler
    - set busy=1
    - load the initial pattern: left/bounce -> bit0 only (00000001); right -> bit WIDTH-1 only (10000000); blink -> all ones.
- RUN:
  - stop=1: go to IDLE on the next edge; led=0, busy=0, cycle_done=0, prescaler cleared.
  - start and mode are ignored; mode_q holds for the whole run.
  - Prescaler counts 0..SHIFT_TIME-1. On the edge where it equals SHIFT_TIME-1, it wraps to 0 and the pattern steps.
  - The first step occurs SHIFT_TIME cycles after the load edge. led updates only on step edges.
- Step rules:
  - Left: rotate left by 1. Wrap 10000000 -> 00000001 asserts cycle_done. Period = WIDTH steps.
  - Right: rotate right by 1. Wrap 00000001 -> 10000000 asserts cycle_done. Period = WIDTH steps.
  - Bounce: shift in the current direction.
    - Reaching bit WIDTH-1 flips direction to right.
    - Reaching bit0 flips direction to left and asserts cycle_done.
    - No bit is held for two steps. Period = 2*(WIDTH-1) steps.
  - Blink: invert led. The step that produces all-ones asserts cycle_done. Period = 2 steps.
- cycle_done is registered, high for exactly one cycle, and coincides with the led update that completes the period. It is 0 at all other times.
- SHIFT_TIME=1: step on every RUN cycle.
- A stop that coincides with a step edge wins: led goes to 0, no cycle_done.
- Prescaler width is $clog2(SHIFT_TIME+1) bits. It never exceeds SHIFT_TIME-1.

Decomposition:
- Shared package led_ctrl_pkg holds:
  - mode encodings MODE_LEFT=2'b00, MODE_RIGHT=2'b01, MODE_BOUNCE=2'b10, MODE_BLINK=2'b11
  - FSM state encodings ST_IDLE, ST_RUN
- One sub-module, step_prescaler (params SHIFT_TIME).
  - Inputs: clk, rst, clr, en.
  - Output: step, a one-cycle pulse every SHIFT_TIME enabled cycles.
  - clr is driven on the load edge and on stop.
- Pattern/next-state logic stays in led_pattern_ctrl.

Test Plan:
All scenarios use defaults (WIDTH=8, SHIFT_TIME=5) and a 4 ns clk period.
1. rst=1 for 3 edges, start=1 held -> led=00000000, busy=0, cycle_done=0 throughout reset. The first post-reset edge with start=1 loads the pattern.
2. mode=00, start pulse -> led=00000001 and busy=1 after the next edge. led=00000010 five cycles later. After 8 steps (40 cycles) led=00000001 with cycle_done high for exactly 1 cycle.
3. mode=10, start -> led walks 01,02,04,...,80,40,...,01 with no repeated value at the ends. cycle_done fires only on the return to 01 (step 14, 70 cycles after load).
4. mode=11, start -> led=FF, 00, FF, ... toggling every 5 cycles. cycle_done fires on each 00->FF step. mode switched to 00 mid-run -> pattern unchanged.
5. mode=01 run; assert stop when led=00100000 -> next edge led=0, busy=0. Then start=1 and stop=1 together -> remains IDLE, led=0.
6. rst pulsed for one cycle during a RUN step edge -> led=0, busy=0, no cycle_done. A subsequent start restarts cleanly with the prescaler at 0 (first step 5 cycles after load).
